full_handshake_tx_q: RTL and testbench

//  Transmit side of the four-phase CDC handshake (req=1, ack=1, req=0, ack=0).

---
 rtl/full_handshake_tx_q.sv | 78 +++++++
 tb/tb_full_handshake_tx_q.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/full_handshake_tx_q.sv
// full_handshake_tx_q: FIFO-fed transmitter for a four-phase req/ack CDC handshake
module full_handshake_tx_q #(
  parameter int DW = 32,
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_valid_i,
  input  logic [DW-1:0] push_data_i,
  output logic          push_ready_o,
  input  logic          ack_i,
  output logic          req_o,
  output logic [DW-1:0] req_data_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW:0]   count_o
);
  typedef enum logic [2:0] {IDLE = 3'b001, ASSERT = 3'b010, DEASSERT = 3'b100} state_t;
  state_t r_state, w_next;
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic r_ack_m, r_ack_s, w_push, w_pop, w_req, w_done;
  assign push_ready_o = r_cnt != (AW+1)'(DEPTH);
  assign w_push = push_valid_i && push_ready_o;
  assign count_o = r_cnt;
  assign busy_o = r_state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) {r_ack_s, r_ack_m} <= '0;
    else {r_ack_s, r_ack_m} <= {r_ack_m, ack_i};
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= push_data_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_push);
      r_rp <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_comb begin
    w_next = r_state;
    w_pop = 1'b0;
    w_req = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        w_pop = r_cnt != '0;
        w_req = w_pop;
        w_next = w_pop ? ASSERT : IDLE;
      end
      ASSERT: begin
        w_req = !r_ack_s;
        w_next = r_ack_s ? DEASSERT : ASSERT;
      end
      DEASSERT: begin
        w_done = !r_ack_s;
        w_next = r_ack_s ? DEASSERT : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      req_o <= 1'b0;
      done_o <= 1'b0;
      req_data_o <= '0;
    end else begin
      r_state <= w_next;
      req_o <= w_req;
      done_o <= w_done;
      if (w_pop) req_data_o <= r_mem[r_rp];
    end
endmodule

// File: tb/tb_full_handshake_tx_q.sv
// tb_full_handshake_tx_q: randomized self-checking bench with a queue-level reference model
module tb_full_handshake_tx_q;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int AW = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic push_valid = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic ack = 1'b0;
  logic push_ready_o, req_o, busy_o, done_o;
  logic [DW-1:0] req_data_o;
  logic [AW:0] count_o;
  always #5 clk = ~clk;
  full_handshake_tx_q #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .push_valid_i(push_valid), .push_data_i(push_data),
    .push_ready_o(push_ready_o), .ack_i(ack), .req_o(req_o), .req_data_o(req_data_o),
    .busy_o(busy_o), .done_o(done_o), .count_o(count_o)
  );
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] pushed[$];
  logic [DW-1:0] got[$];
  logic [DW-1:0] m_data = '0;
  int phase = 0;
  logic m_req = 1'b0;
  logic m_done = 1'b0;
  logic h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;
  logic last_acc = 1'b0;
  bit rx_en = 1'b0;
  int rx_mode = 2;
  int rx_wait = 0;
  int rx_dly = 3;
  int sw = 0;
  int n_done = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic pick_dly();
    if (rx_mode == 2) rx_dly = 3;
    else if (rx_mode == 1) begin
      rx_dly = (sw % 8) + 1;
      sw++;
    end else rx_dly = $urandom_range(1, 8);
  endtask
  task automatic cyc();
    logic acc;
    logic [DW-1:0] d;
    acc = push_valid && push_ready_o;
    d = push_data;
    h2 = h1;
    h1 = h0;
    h0 = ack;
    @(posedge clk);
    #1;
    m_done = 1'b0;
    if (phase == 0 && q.size() > 0) begin
      m_data = q.pop_front();
      m_req = 1'b1;
      phase = 1;
    end else if (phase == 1 && h2) begin
      m_req = 1'b0;
      phase = 2;
    end else if (phase == 2 && !h2) begin
      m_done = 1'b1;
      phase = 0;
    end
    if (acc) begin
      q.push_back(d);
      pushed.push_back(d);
    end
    last_acc = acc;
    chk("req", req_o, m_req);
    chk("done", done_o, m_done);
    chk("busy", busy_o, phase != 0);
    chk("count", count_o, q.size());
    chk("ready", push_ready_o, q.size() != DEPTH);
    chk("data", req_data_o, m_data);
    if (done_o) n_done++;
    if (rx_en) begin
      if (req_o != ack) begin
        rx_wait++;
        if (rx_wait >= rx_dly) begin
          if (!ack) got.push_back(req_data_o);
          ack = req_o;
          rx_wait = 0;
          pick_dly();
        end
      end else rx_wait = 0;
    end
  endtask
  task automatic push_word(input logic [DW-1:0] d, input int budget, output bit ok);
    ok = 1'b0;
    push_data = d;
    push_valid = 1'b1;
    for (int t = 0; t < budget && !ok; t++) begin
      cyc();
      ok = last_acc;
    end
    push_valid = 1'b0;
  endtask
  task automatic check_order();
    chk("rx_le_pushed", got.size() <= pushed.size(), 1);
    for (int i = 0; i < got.size() && i < pushed.size(); i++) chk("order", got[i], pushed[i]);
  endtask
  task automatic drain(input int budget);
    push_valid = 1'b0;
    for (int t = 0; t < budget && !(q.size() == 0 && phase == 0 && !ack && got.size() == pushed.size()); t++) cyc();
    chk("drain", {q.size() == 0, phase == 0, got.size() == pushed.size()}, 3'b111);
    check_order();
    chk("done_total", n_done, got.size());
  endtask
  task automatic reset_checks(input string tag);
    chk({tag, "_req"}, req_o, 0);
    chk({tag, "_count"}, count_o, 0);
    chk({tag, "_ready"}, push_ready_o, 1);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_data"}, req_data_o, 0);
  endtask
  task automatic model_clear();
    q.delete();
    pushed.delete();
    got.delete();
    phase = 0;
    m_req = 1'b0;
    m_done = 1'b0;
    m_data = '0;
    {h0, h1, h2} = 3'b000;
    ack = 1'b0;
    rx_wait = 0;
    n_done = 0;
  endtask
  initial begin
    bit ok;
    int hits;
    #2 rst = 1'b1;
    #1 reset_checks("por");
    repeat (2) @(posedge clk);
    #1 reset_checks("por_hold");
    @(negedge clk) rst = 1'b0;
    model_clear();
    rx_en = 1'b0;
    for (int k = 0; k < 3; k++) push_word(32'h1111_0000 + k, 4, ok);
    for (int t = 0; t < 10 && !req_o; t++) cyc();
    chk("t1_req_up", req_o, 1);
    cyc();
    #3 rst = 1'b1;
    ack = 1'b0;
    #1 reset_checks("t1_async");
    repeat (2) @(posedge clk);
    #1 reset_checks("t1_hold");
    @(negedge clk) rst = 1'b0;
    check_order();
    model_clear();
    repeat (8) cyc();
    chk("t1_no_done", n_done, 0);
    rx_en = 1'b1;
    rx_mode = 2;
    pick_dly();
    push_word(32'hA5A5_0001, 4, ok);
    chk("t2_acc", ok, 1);
    drain(60);
    chk("t2_word", got.size() > 0 ? got[0] : '0, 32'hA5A5_0001);
    chk("t2_one_done", n_done, 1);
    rx_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      push_word(32'h3000_0000 + k, 8, ok);
      chk("t3_acc", ok, 1);
    end
    cyc();
    chk("t3_count", count_o, 4);
    chk("t3_ready", push_ready_o, 0);
    chk("t3_inflight", req_o, 1);
    push_word(32'h3000_0005, 6, ok);
    chk("t3_stall", ok, 0);
    rx_en = 1'b1;
    rx_mode = 0;
    pick_dly();
    push_word(32'h3000_0005, 80, ok);
    chk("t3_late_acc", ok, 1);
    drain(300);
    for (int k = 1; k <= 4; k++) begin
      push_word(DW'(k), 20, ok);
      chk("t4_acc", ok, 1);
    end
    drain(300);
    rx_mode = 2;
    pick_dly();
    for (int k = 0; k < 3; k++) push_word(32'h5000_0000 + k, 10, ok);
    hits = 0;
    for (int t = 0; t < 200 && hits < 3; t++) begin
      push_valid = (count_o < 2) || done_o;
      push_data = $urandom;
      if (done_o && count_o == 2) begin
        cyc();
        hits++;
        chk("t5_cnt_hold", count_o, 2);
        chk("t5_popped", req_o, 1);
      end else cyc();
    end
    chk("t5_hits", hits, 3);
    drain(300);
    rx_mode = 1;
    pick_dly();
    for (int k = 0; k < 3 * DEPTH + 1; k++) begin
      push_word($urandom, 60, ok);
      chk("t6_acc", ok, 1);
    end
    drain(400);
    rx_mode = 0;
    for (int t = 0; t < 300; t++) begin
      push_valid = $urandom_range(0, 1) == 1;
      push_data = $urandom;
      cyc();
    end
    drain(400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
